// File: rtl/pic_frame_parser.sv
// pic_frame_parser: pops framed commands from the UART RX FIFO and turns them
// into a 9-bit LCD word stream (window -> CASET/RASET/RAMWR sequence, pixels
// -> data words). Frame: HEADER, TYPE, LEN_H, LEN_L, payload, CSUM.
module pic_frame_parser #(
  parameter logic [23:0] TIMEOUT = 24'd1_200_000,
  parameter logic [7:0]  HEADER  = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init_done,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  output logic       fifo_rd_en,
  input  logic       wr_done,
  output logic [8:0] pic_data,
  output logic       en_write,
  output logic       busy,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code
);

  typedef enum logic [3:0] {
    S_IDLE, S_TYPE, S_LEN_H, S_LEN_L, S_WIN_BUF, S_PIX, S_CSUM, S_WIN_EMIT, S_SKIP
  } state_t;

  state_t          state_q, state_d;
  logic            rd_en_q, rd_en_d;
  logic            byte_vld_q, byte_vld_d;   // fifo_data holds a fresh byte this cycle
  logic            wr_pend_q, wr_pend_d;     // word issued, waiting for wr_done
  logic            en_write_q, en_write_d;
  logic [8:0]      pic_data_q, pic_data_d;
  logic            frame_ok_q, frame_ok_d;
  logic            frame_err_q, frame_err_d;
  logic [1:0]      err_code_q, err_code_d;
  logic [7:0]      sum_q, sum_d;
  logic [16:0]     len_q, len_d;             // bytes remaining; 17 bits so SKIP can hold LEN+1
  logic            is_win_q, is_win_d;
  logic            bad_q, bad_d;
  logic [7:0][7:0] win_q, win_d;             // x0h,x0l,x1h,x1l,y0h,y0l,y1h,y1l at index 0..7
  logic [3:0]      widx_q, widx_d;
  logic [23:0]     tmo_q, tmo_d;

  logic        wr_ack, counting, want_byte;
  logic [16:0] lenw;

  // Window burst word i of the 11-word CASET/RASET/RAMWR sequence
  function automatic logic [8:0] win_word(input logic [3:0] i, input logic [7:0][7:0] w);
    logic [8:0] r;
    case (i)
      4'd0:    r = 9'h02A;
      4'd1:    r = {1'b1, w[0]};
      4'd2:    r = {1'b1, w[1]};
      4'd3:    r = {1'b1, w[2]};
      4'd4:    r = {1'b1, w[3]};
      4'd5:    r = 9'h02B;
      4'd6:    r = {1'b1, w[4]};
      4'd7:    r = {1'b1, w[5]};
      4'd8:    r = {1'b1, w[6]};
      4'd9:    r = {1'b1, w[7]};
      default: r = 9'h02C;
    endcase
    return r;
  endfunction

  // Next-state, datapath and handshake decisions
  always_comb begin
    state_d     = state_q;
    byte_vld_d  = rd_en_q;
    wr_pend_d   = wr_pend_q;
    en_write_d  = 1'b0;
    pic_data_d  = pic_data_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    sum_d       = sum_q;
    len_d       = len_q;
    is_win_d    = is_win_q;
    bad_d       = bad_q;
    win_d       = win_q;
    widx_d      = widx_q;
    tmo_d       = tmo_q;
    rd_en_d     = 1'b0;

    // A wr_done coincident with en_write belongs to nothing we issued
    wr_ack = wr_done && wr_pend_q && !en_write_q;
    if (wr_ack) wr_pend_d = 1'b0;

    lenw = {1'b0, len_q[15:8], fifo_data};

    // Idle time is only charged while waiting on the FIFO, never on the LCD
    counting = (state_q != S_IDLE) && (state_q != S_WIN_EMIT) && !wr_pend_q && !byte_vld_q;
    if (byte_vld_q || wr_done || state_q == S_IDLE) tmo_d = '0;
    else if (counting)                             tmo_d = tmo_q + 24'd1;

    case (state_q)
      S_IDLE: if (byte_vld_q && fifo_data == HEADER) begin
        state_d = S_TYPE;
        sum_d   = '0;
      end
      S_TYPE: if (byte_vld_q) begin
        sum_d    = sum_q + fifo_data;
        is_win_d = (fifo_data == 8'h01);
        bad_d    = (fifo_data != 8'h01) && (fifo_data != 8'h02);
        state_d  = S_LEN_H;
      end
      S_LEN_H: if (byte_vld_q) begin
        sum_d   = sum_q + fifo_data;
        len_d   = {1'b0, fifo_data, 8'h00};
        state_d = S_LEN_L;
      end
      S_LEN_L: if (byte_vld_q) begin
        sum_d = sum_q + fifo_data;
        len_d = lenw;
        if (bad_q || (is_win_q && lenw != 17'd8)) begin
          len_d   = lenw + 17'd1;
          state_d = S_SKIP;
        end else if (is_win_q)     state_d = S_WIN_BUF;
        else if (lenw == 17'd0)    state_d = S_CSUM;
        else                       state_d = S_PIX;
      end
      S_WIN_BUF: if (byte_vld_q) begin
        win_d[3'(4'd8 - len_q[3:0])] = fifo_data;
        sum_d = sum_q + fifo_data;
        len_d = len_q - 17'd1;
        if (len_q == 17'd1) state_d = S_CSUM;
      end
      S_PIX: if (byte_vld_q) begin
        pic_data_d = {1'b1, fifo_data};
        en_write_d = 1'b1;
        wr_pend_d  = 1'b1;
        sum_d      = sum_q + fifo_data;
        len_d      = len_q - 17'd1;
        if (len_q == 17'd1) state_d = S_CSUM;
      end
      S_CSUM: if (byte_vld_q) begin
        if (fifo_data != sum_q) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'd1;
          state_d     = S_IDLE;
        end else if (is_win_q) begin
          widx_d     = '0;
          pic_data_d = win_word(4'd0, win_q);
          en_write_d = 1'b1;
          wr_pend_d  = 1'b1;
          state_d    = S_WIN_EMIT;
        end else begin
          frame_ok_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_WIN_EMIT: if (wr_ack) begin
        if (widx_q == 4'd10) begin
          frame_ok_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          widx_d     = widx_q + 4'd1;
          pic_data_d = win_word(widx_q + 4'd1, win_q);
          en_write_d = 1'b1;
          wr_pend_d  = 1'b1;
        end
      end
      S_SKIP: if (byte_vld_q) begin
        len_d = len_q - 17'd1;
        if (len_q == 17'd1) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'd2;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // counting excludes byte cycles and WIN_EMIT, so this never collides with frame_ok
    if (counting && tmo_q == TIMEOUT - 24'd1) begin
      frame_err_d = 1'b1;
      err_code_d  = 2'd3;
      state_d     = S_IDLE;
    end

    // One read in flight; pixel pops wait for the previous word's wr_done
    want_byte = (state_d != S_WIN_EMIT) && !wr_pend_d;
    rd_en_d   = want_byte && !rd_en_q && init_done && !fifo_empty;
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rd_en_q     <= 1'b0;
      byte_vld_q  <= 1'b0;
      wr_pend_q   <= 1'b0;
      en_write_q  <= 1'b0;
      pic_data_q  <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
      sum_q       <= '0;
      len_q       <= '0;
      is_win_q    <= 1'b0;
      bad_q       <= 1'b0;
      win_q       <= '0;
      widx_q      <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      rd_en_q     <= rd_en_d;
      byte_vld_q  <= byte_vld_d;
      wr_pend_q   <= wr_pend_d;
      en_write_q  <= en_write_d;
      pic_data_q  <= pic_data_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      sum_q       <= sum_d;
      len_q       <= len_d;
      is_win_q    <= is_win_d;
      bad_q       <= bad_d;
      win_q       <= win_d;
      widx_q      <= widx_d;
      tmo_q       <= tmo_d;
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign en_write   = en_write_q;
  assign pic_data   = pic_data_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_ok   = frame_ok_q;
  assign frame_err  = frame_err_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_pic_frame_parser.sv
// Bench for pic_frame_parser: FIFO + lcd_write models, frame-level reference
// model feeding word/event scoreboards, monitor checks at the falling edge.
module tb_pic_frame_parser;
  localparam logic [23:0] TMO = 24'd100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       init_done = 1'b0;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_empty = 1'b1;
  logic       wr_done = 1'b0;
  logic       fifo_rd_en, en_write, busy, frame_ok, frame_err;
  logic [8:0] pic_data;
  logic [1:0] err_code;

  always #5 clk = ~clk;

  pic_frame_parser #(.TIMEOUT(TMO), .HEADER(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .wr_done(wr_done), .pic_data(pic_data), .en_write(en_write), .busy(busy),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code)
  );

  typedef struct { logic [8:0] w; bit burst; } wexp_t;

  logic [7:0] fifo_q[$];
  wexp_t      exp_w[$];
  int         exp_e[$];   // 0 = frame_ok, 1..3 = frame_err with that err_code
  int n_chk = 0, n_pass = 0;
  int cyc = 0, last_done = -10, wr_cnt = 0, n_wr = 0;
  bit pend = 0, rnd_phase = 0;
  logic [8:0] last_word = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // FIFO model: Q updates after a sampled pop, empty flag tracks the queue
  initial forever begin
    @(negedge clk);
    if (fifo_rd_en) begin
      if (fifo_q.size() == 0) chk("pop_on_empty", 1, 0);
      else fifo_data = fifo_q.pop_front();
    end
    fifo_empty = (fifo_q.size() == 0);
  end

  // lcd_write model plus write/event monitor
  initial forever begin
    wexp_t e;
    int    ev;
    @(negedge clk);
    wr_done = 1'b0;
    if (!rst_n) begin
      wr_cnt = 0;
      pend   = 0;
    end else begin
      if (en_write) begin
        n_wr++;
        chk("write_overlap", 32'(pend), 0);
        if (exp_w.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_write: got word 0x%0h, expected no write", pic_data);
        end else begin
          e = exp_w.pop_front();
          chk("word", 32'(pic_data), 32'(e.w));
          if (e.burst) chk("burst_gap", cyc - last_done, 1);
        end
        last_word = pic_data;
        pend      = 1;
        wr_cnt    = $urandom_range(1, 3);
      end else if (pend) begin
        chk("pic_data_hold", 32'(pic_data), 32'(last_word));
        wr_cnt--;
        if (wr_cnt == 0) begin
          wr_done   = 1'b1;
          pend      = 0;
          last_done = cyc;
        end
      end
      if (frame_ok && frame_err) chk("ok_err_same_cycle", 1, 0);
      if (frame_ok || frame_err) begin
        if (exp_e.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_event: got ok=%0b err=%0b code=%0d, expected none",
                   frame_ok, frame_err, err_code);
        end else begin
          ev = exp_e.pop_front();
          if (ev == 0) chk("frame_ok", {31'd0, frame_ok}, 1);
          else begin
            chk("frame_err", {31'd0, frame_err}, 1);
            chk("err_code", 32'(err_code), 32'(ev));
          end
        end
      end
    end
  end

  // Occasional init_done drops during the random phase
  initial forever begin
    @(negedge clk);
    if (rnd_phase && $urandom_range(0, 15) == 0) begin
      init_done = 1'b0;
      repeat (4) @(negedge clk);
      init_done = 1'b1;
    end
  end

  // Reference model: build the byte stream and the expected words/events
  task automatic send_frame(input logic [7:0] typ, input logic [7:0] pl[$], input int cs_ovr,
                            input int n_junk);
    logic [15:0] len;
    logic [7:0]  sum, cs, j;
    wexp_t       e;
    len = 16'(pl.size());
    sum = typ + len[15:8] + len[7:0];
    foreach (pl[i]) sum = sum + pl[i];
    cs = (cs_ovr == -1) ? sum : (cs_ovr == -2) ? (sum ^ 8'h5A) : 8'(cs_ovr);
    if (!(typ == 8'h01 || typ == 8'h02) || (typ == 8'h01 && len != 16'd8)) exp_e.push_back(2);
    else if (typ == 8'h02) begin
      foreach (pl[i]) begin e.w = {1'b1, pl[i]}; e.burst = 0; exp_w.push_back(e); end
      exp_e.push_back(cs == sum ? 0 : 1);
    end else if (cs != sum) exp_e.push_back(1);
    else begin
      for (int i = 0; i < 11; i++) begin
        e.burst = (i != 0);
        if (i == 0)       e.w = 9'h02A;
        else if (i < 5)   e.w = {1'b1, pl[i-1]};
        else if (i == 5)  e.w = 9'h02B;
        else if (i < 10)  e.w = {1'b1, pl[i-2]};
        else              e.w = 9'h02C;
        exp_w.push_back(e);
      end
      exp_e.push_back(0);
    end
    for (int i = 0; i < n_junk; i++) begin
      j = 8'($urandom_range(0, 255));
      fifo_q.push_back(j == 8'hA5 ? 8'h00 : j);
    end
    fifo_q.push_back(8'hA5);
    fifo_q.push_back(typ);
    fifo_q.push_back(len[15:8]);
    fifo_q.push_back(len[7:0]);
    foreach (pl[i]) fifo_q.push_back(pl[i]);
    fifo_q.push_back(cs);
  endtask

  task automatic wait_idle(input string nm);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_w.size() == 0 && exp_e.size() == 0 && fifo_q.size() == 0) break;
    end
    chk({nm, "_drain"}, 32'(i < 3000), 1);
    chk({nm, "_busy"}, {31'd0, busy}, 0);
  endtask

  initial begin
    logic [7:0] pl[$];
    logic [7:0] typ;
    int kind, cs_ovr, base, i;
    bit rd_seen;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_rd_en", {31'd0, fifo_rd_en}, 0);
    chk("rst_en_write", {31'd0, en_write}, 0);
    chk("rst_pic_data", 32'(pic_data), 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_frame_ok", {31'd0, frame_ok}, 0);
    chk("rst_frame_err", {31'd0, frame_err}, 0);
    chk("rst_err_code", 32'(err_code), 0);
    rst_n = 1'b1;

    // No FIFO reads while init_done is low
    fifo_q.push_back(8'h00);
    rd_seen = 0;
    repeat (6) begin @(negedge clk); rd_seen |= fifo_rd_en; end
    chk("no_read_before_init", {31'd0, rd_seen}, 0);
    init_done = 1'b1;
    wait_idle("init_junk");

    // Directed frames
    pl = {8'h00, 8'h00, 8'h00, 8'hEF, 8'h00, 8'h00, 8'h01, 8'h3F};
    send_frame(8'h01, pl, 8'h38, 0);
    wait_idle("window");
    pl = {8'hF8, 8'h00, 8'h1F};
    send_frame(8'h02, pl, 8'h1C, 0);
    wait_idle("pixels");
    pl = {8'h00, 8'h00, 8'h00, 8'hEF, 8'h00, 8'h00, 8'h01, 8'h3F};
    send_frame(8'h01, pl, 8'h00, 0);
    wait_idle("bad_csum");
    fifo_q.push_back(8'h00); fifo_q.push_back(8'h55); fifo_q.push_back(8'hFF);
    pl = {8'h12, 8'h34};
    send_frame(8'h02, pl, -1, 0);
    wait_idle("garbage");
    pl = {8'hA5, 8'h01};
    send_frame(8'h07, pl, -1, 0);
    wait_idle("bad_type");
    pl.delete();
    send_frame(8'h02, pl, -1, 0);
    wait_idle("pix_len0");

    // Timeout after A5 02
    fifo_q.push_back(8'hA5);
    fifo_q.push_back(8'h02);
    exp_e.push_back(3);
    wait_idle("timeout");

    // Reset in the middle of a window burst
    pl = {8'h00, 8'h10, 8'h00, 8'h20, 8'h00, 8'h30, 8'h00, 8'h40};
    send_frame(8'h01, pl, -1, 0);
    base = n_wr;
    for (i = 0; i < 2000 && n_wr < base + 3; i++) @(negedge clk);
    chk("burst_started", 32'(n_wr >= base + 3), 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_w.delete();
    exp_e.delete();
    @(posedge clk); #1;
    chk("midrst_en_write", {31'd0, en_write}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_pic_data", 32'(pic_data), 0);
    rst_n = 1'b1;
    pl = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_frame(8'h01, pl, -1, 1);
    wait_idle("after_reset");

    // Randomized frames
    rnd_phase = 1;
    for (int f = 0; f < 30; f++) begin
      kind   = $urandom_range(0, 5);
      cs_ovr = -1;
      typ    = 8'h02;
      pl.delete();
      case (kind)
        0, 1: begin
          typ = 8'h01;
          for (int k = 0; k < 8; k++) pl.push_back(8'($urandom_range(0, 255)));
          if (kind == 1) cs_ovr = -2;
        end
        2: begin
          for (int k = 0; k < int'($urandom_range(1, 6)); k++) pl.push_back(8'($urandom_range(0, 255)));
          if ($urandom_range(0, 3) == 0) cs_ovr = -2;
        end
        3: begin
          typ = 8'($urandom_range(3, 255));
          for (int k = 0; k < int'($urandom_range(0, 4)); k++) pl.push_back(8'($urandom_range(0, 255)));
        end
        4: begin
          typ = 8'h01;
          kind = $urandom_range(0, 9);
          if (kind == 8) kind = 10;
          for (int k = 0; k < kind; k++) pl.push_back(8'($urandom_range(0, 255)));
        end
        default: ;
      endcase
      send_frame(typ, pl, cs_ovr, $urandom_range(0, 3));
      wait_idle("random");
    end
    rnd_phase = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
